// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL bring-up sequencer.
//   Pulses pll_rst, waits for the PLL to report lock, then requires the lock
//   to hold for STABLE_CYCLES before asserting a qualified lock. Failed
//   attempts are retried up to MAX_RETRY times before parking in FAIL.
//
//   Optional feature macro PLL_SEQ_SWEEP_EN: when defined, every non-final
//   failed attempt steps the loop-filter settings (icpsel +1 saturating,
//   lpfres +1 wrapping). When undefined, icpsel/lpfres are tied to their
//   initial values and no sweep logic exists.
//
// Ports
//   clkin      in   sole clock
//   reset      in   asynchronous, active-high reset
//   pll_lock   in   raw PLL lock (asynchronous to clkin)
//   relock_req in   single-cycle restart request, beats every other transition
//   pll_rst    out  PLL reset, active-high
//   icpsel     out  [5:0] charge-pump current select
//   lpfres     out  [2:0] loop-filter resistor select
//   lock       out  qualified, stable lock
//   fail       out  retries exhausted
//   retry_cnt  out  [3:0] failed-attempt count
module pll_lock_seq #(
  parameter int         RST_CYCLES    = 16,
  parameter int         LOCK_TIMEOUT  = 4096,
  parameter int         STABLE_CYCLES = 64,
  parameter int         MAX_RETRY     = 8,
  parameter logic [5:0] ICPSEL_INIT   = 6'd8,
  parameter logic [2:0] LPFRES_INIT   = 3'd2
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic [5:0] icpsel,
  output logic [2:0] lpfres,
  output logic       lock,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  localparam int MAXC0 = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int MAXC  = (MAXC0 > LOCK_TIMEOUT) ? MAXC0 : LOCK_TIMEOUT;
  localparam int CW    = (MAXC > 2) ? $clog2(MAXC) : 1;

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          sync1, lock_s;
  logic          attempt_fail, final_fail;
  logic [3:0]    retry_inc;

  // Two-flop synchronizer; nothing downstream looks at raw pll_lock.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_lock;
      lock_s <= sync1;
    end
  end

  // An attempt fails on WAIT timeout or on any lock loss while qualifying.
  assign attempt_fail = !lock_s &&
                        ((state == S_WAIT && cnt == CW'(LOCK_TIMEOUT - 1)) ||
                         state == S_STABLE);
  assign retry_inc    = retry_cnt + 4'd1;
  assign final_fail   = (retry_inc == 4'(MAX_RETRY));

  // Outputs are updated on the same edge as the state they describe, so
  // every output is a flop and follows the state with no extra lag.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state     <= S_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      lock      <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else if (relock_req) begin
      state     <= S_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      lock      <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else if (attempt_fail) begin
      state     <= final_fail ? S_FAIL : S_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      fail      <= final_fail;
      retry_cnt <= retry_inc;
    end else begin
      case (state)
        S_RST: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            state   <= S_WAIT;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (lock_s) begin
            state <= S_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STABLE: begin
          // lock_s is known high here; a low lock_s took the failure branch.
          if (cnt == CW'(STABLE_CYCLES - 1)) begin
            state     <= S_LOCKED;
            cnt       <= '0;
            lock      <= 1'b1;
            retry_cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LOCKED: begin
          // Lock loss after qualification is not a failed attempt:
          // restart without touching retry count or settings.
          if (!lock_s) begin
            state   <= S_RST;
            cnt     <= '0;
            lock    <= 1'b0;
            pll_rst <= 1'b1;
          end
        end
        S_FAIL: begin
        end
        default: begin
          state   <= S_RST;
          cnt     <= '0;
          pll_rst <= 1'b1;
          lock    <= 1'b0;
          fail    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_SEQ_SWEEP_EN
  // The final failure leaves the settings at the last values tried.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      icpsel <= ICPSEL_INIT;
      lpfres <= LPFRES_INIT;
    end else if (relock_req) begin
      icpsel <= ICPSEL_INIT;
      lpfres <= LPFRES_INIT;
    end else if (attempt_fail && !final_fail) begin
      icpsel <= (icpsel == 6'd63) ? icpsel : icpsel + 6'd1;
      lpfres <= lpfres + 3'd1;
    end
  end
`else
  assign icpsel = ICPSEL_INIT;
  assign lpfres = LPFRES_INIT;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// Bench for pll_lock_seq (default parameters): a table of directed steps,
// a hand-written timeout/FAIL/relock sequence, then random stimulus checked
// cycle by cycle against a behavioural model.
module tb_pll_lock_seq;

  localparam int RST_N  = 16;
  localparam int TMO_N  = 4096;
  localparam int STB_N  = 64;
  localparam int MAXR   = 8;
  localparam int ICP0   = 8;
  localparam int LPF0   = 2;

  logic       clkin = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_rst;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic       lock;
  logic       fail;
  logic [3:0] retry_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  pll_lock_seq dut (
    .clkin      (clkin),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .icpsel     (icpsel),
    .lpfres     (lpfres),
    .lock       (lock),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  // Expected settings depend on whether the sweep is built in.
  function automatic int e_icp(input int v);
`ifdef PLL_SEQ_SWEEP_EN
    return v;
`else
    return (v >= 0) ? ICP0 : ICP0;
`endif
  endfunction

  function automatic int e_lpf(input int v);
`ifdef PLL_SEQ_SWEEP_EN
    return v;
`else
    return (v >= 0) ? LPF0 : LPF0;
`endif
  endfunction

  task automatic step(input bit l, input bit r, input int n);
    pll_lock   = l;
    relock_req = r;
    repeat (n) @(negedge clkin);
    relock_req = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int rst, input int lk, input int fl,
                         input int rc, input int icp, input int lpf);
    chk({tag, ".pll_rst"},   int'(pll_rst),   rst);
    chk({tag, ".lock"},      int'(lock),      lk);
    chk({tag, ".fail"},      int'(fail),      fl);
    chk({tag, ".retry_cnt"}, int'(retry_cnt), rc);
    chk({tag, ".icpsel"},    int'(icpsel),    e_icp(icp));
    chk({tag, ".lpfres"},    int'(lpfres),    e_lpf(lpf));
  endtask

  // ---------------- behavioural reference model ----------------
  // Phase plus elapsed time in phase; the synchronizer is a two-deep history.
  localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_LCK = 3, P_FAIL = 4;
  int m_phase, m_t, m_retry, m_icp, m_lpf;
  bit m_h1, m_h2;

  task automatic m_failed();
    m_retry++;
    m_t = 0;
    if (m_retry == MAXR) m_phase = P_FAIL;
    else begin
      m_phase = P_RST;
`ifdef PLL_SEQ_SWEEP_EN
      m_icp = (m_icp + 1 > 63) ? 63 : m_icp + 1;
      m_lpf = (m_lpf + 1) % 8;
`endif
    end
  endtask

  always @(posedge clkin or posedge reset) begin
    if (reset) begin
      m_phase = P_RST; m_t = 0; m_retry = 0; m_icp = ICP0; m_lpf = LPF0;
      m_h1 = 1'b0; m_h2 = 1'b0;
    end else begin
      bit seen;
      seen = m_h2;
      m_h2 = m_h1;
      m_h1 = pll_lock;
      if (relock_req) begin
        m_phase = P_RST; m_t = 0; m_retry = 0; m_icp = ICP0; m_lpf = LPF0;
      end else begin
        case (m_phase)
          P_RST: begin
            m_t++;
            if (m_t == RST_N) begin m_phase = P_WAIT; m_t = 0; end
          end
          P_WAIT: begin
            if (seen) begin m_phase = P_STB; m_t = 0; end
            else begin
              m_t++;
              if (m_t == TMO_N) m_failed();
            end
          end
          P_STB: begin
            if (!seen) m_failed();
            else begin
              m_t++;
              if (m_t == STB_N) begin m_phase = P_LCK; m_t = 0; m_retry = 0; end
            end
          end
          P_LCK: if (!seen) begin m_phase = P_RST; m_t = 0; end
          default: ;
        endcase
      end
    end
  end

  function automatic int model_vec();
    bit mr, ml, mf;
    mr = (m_phase == P_RST) || (m_phase == P_FAIL);
    ml = (m_phase == P_LCK);
    mf = (m_phase == P_FAIL);
    return int'({mr, ml, mf, 4'(m_retry), 6'(m_icp), 3'(m_lpf)});
  endfunction

  function automatic int dut_vec();
    return int'({pll_rst, lock, fail, retry_cnt, icpsel, lpfres});
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    bit l; bit r; int n;
    int rst; int lk; int fl; int rc; int icp; int lpf;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{0, 0, 15, 1, 0, 0, 0, 8, 2};  // still in 16-cycle reset pulse
    tbl[1]  = '{0, 0, 1,  0, 0, 0, 0, 8, 2};  // WAIT
    tbl[2]  = '{1, 0, 66, 0, 0, 0, 0, 8, 2};  // lock not yet qualified
    tbl[3]  = '{1, 0, 1,  0, 1, 0, 0, 8, 2};  // lock 67 cycles after pll_lock
    tbl[4]  = '{0, 0, 2,  0, 1, 0, 0, 8, 2};  // drop not yet through sync
    tbl[5]  = '{0, 0, 1,  1, 0, 0, 0, 8, 2};  // lock falls 3 cycles later
    tbl[6]  = '{0, 0, 15, 1, 0, 0, 0, 8, 2};
    tbl[7]  = '{0, 0, 1,  0, 0, 0, 0, 8, 2};  // 16-cycle relock pulse
    tbl[8]  = '{1, 0, 33, 0, 0, 0, 0, 8, 2};  // STABLE count 30
    tbl[9]  = '{0, 0, 3,  1, 0, 0, 1, 9, 3};  // glitch -> failure
    tbl[10] = '{1, 0, 15, 1, 0, 0, 1, 9, 3};
    tbl[11] = '{1, 0, 1,  0, 0, 0, 1, 9, 3};
    tbl[12] = '{1, 0, 64, 0, 0, 0, 1, 9, 3};
    tbl[13] = '{1, 0, 1,  0, 1, 0, 0, 9, 3};  // retry cleared, settings kept
    tbl[14] = '{0, 1, 1,  1, 0, 0, 0, 8, 2};  // relock_req from LOCKED
    tbl[15] = '{0, 0, 16, 0, 0, 0, 0, 8, 2};

    reset = 1'b1; pll_lock = 1'b0; relock_req = 1'b0;
    repeat (3) @(negedge clkin);
    chk_all("reset", 1, 0, 0, 0, 8, 2);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].l, tbl[i].r, tbl[i].n);
      chk_all($sformatf("row%0d", i), tbl[i].rst, tbl[i].lk, tbl[i].fl,
              tbl[i].rc, tbl[i].icp, tbl[i].lpf);
    end

    // Eight WAIT timeouts with pll_lock held low, then FAIL.
    for (int a = 0; a < MAXR; a++) begin
      int k;
      k = (a + 1 < 7) ? a + 1 : 7;
      step(0, 0, TMO_N - 1);
      chk($sformatf("tmo%0d.pre_rst", a), int'(pll_rst), 0);
      step(0, 0, 1);
      chk($sformatf("tmo%0d.pll_rst", a), int'(pll_rst), 1);
      chk($sformatf("tmo%0d.retry", a), int'(retry_cnt), a + 1);
      chk($sformatf("tmo%0d.icpsel", a), int'(icpsel), e_icp(ICP0 + k));
      chk($sformatf("tmo%0d.lpfres", a), int'(lpfres), e_lpf((LPF0 + k) % 8));
      chk($sformatf("tmo%0d.fail", a), int'(fail), (a == MAXR - 1) ? 1 : 0);
      if (a < MAXR - 1) begin
        step(0, 0, RST_N);
        chk($sformatf("tmo%0d.wait", a), int'(pll_rst), 0);
      end
    end
    step(1, 0, 100);  // FAIL holds regardless of pll_lock
    chk_all("fail_hold", 1, 0, 1, 8, 15, 1);
    step(0, 1, 1);
    chk_all("relock_fail", 1, 0, 0, 0, 8, 2);
    step(0, 0, 15);
    chk("relock_fail.pulse", int'(pll_rst), 1);
    step(0, 0, 1);
    chk("relock_fail.end", int'(pll_rst), 0);

    // Random phase against the model.
    reset = 1'b1;
    @(negedge clkin);
    reset = 1'b0;
    begin
      int run;
      bit lvl;
      run = 0; lvl = 1'b0;
      for (int c = 0; c < 15000 && (n_chk - n_pass) <= 10; c++) begin
        @(negedge clkin);
        chk("rand.outs", dut_vec(), model_vec());
        if (run == 0) begin
          lvl = 1'($urandom_range(0, 1));
          run = $urandom_range(1, 150);
        end
        run--;
        pll_lock   = lvl;
        relock_req = ($urandom_range(0, 299) == 0);
        if (reset) reset = 1'b0;
        else if ($urandom_range(0, 1999) == 0) begin
          reset = 1'b1;
          #1;
          chk("rand.async_rst", dut_vec(), model_vec());
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pll_lock_seq.md
PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: pll_rst assertion length per attempt, in clkin cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096: clkin cycles allowed in WAIT before an attempt fails.
REQ-003 SHALL have parameter STABLE_CYCLES, default 64: consecutive synced-lock cycles needed to qualify lock.
REQ-004 SHALL have parameter MAX_RETRY, default 8: failed attempts before FAIL.
REQ-005 SHALL have parameters ICPSEL_INIT (default 6'd8) and LPFRES_INIT (default 3'd2): initial loop-filter settings.
REQ-006 SHALL have port clkin  in  1  sole clock.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port pll_lock  in  1  raw PLL lock, asynchronous to clkin.
REQ-009 SHALL have port relock_req  in  1  single-cycle request to restart sequencing.
REQ-010 SHALL have port pll_rst  out  1  PLL reset, active-high.
REQ-011 SHALL have port icpsel  out  6  charge-pump current select to PLL.
REQ-012 SHALL have port lpfres  out  3  loop-filter resistor select to PLL.
REQ-013 SHALL have port lock  out  1  qualified, stable lock.
REQ-014 SHALL have port fail  out  1  sequencing exhausted.
REQ-015 SHALL have port retry_cnt  out  4  failed-attempt count.

Function
REQ-016 SHALL synchronize pll_lock through two clkin flops into lock_s; all decisions SHALL use lock_s only.
REQ-017 SHALL implement FSM states RST, WAIT, STABLE, LOCKED and FAIL, with one shared cycle counter cleared on every state entry.
REQ-018 In RST: pll_rst=1 for exactly RST_CYCLES cycles, then -> WAIT.
REQ-019 In WAIT: pll_rst=0; lock_s=1 -> STABLE; counter reaching LOCK_TIMEOUT-1 with lock_s=0 -> failure.
REQ-020 In STABLE: lock_s=0 -> failure; lock_s=1 for STABLE_CYCLES consecutive cycles -> LOCKED.
REQ-021 In LOCKED: lock=1 from the first LOCKED cycle; retry_cnt cleared on entry; lock_s=0 -> lock=0 on the next cycle and -> RST, with retry_cnt, icpsel and lpfres unchanged.
REQ-022 On a failure, retry_cnt SHALL increment; if the new value equals MAX_RETRY -> FAIL, else -> RST with the settings stepped per REQ-029.
REQ-023 In FAIL: pll_rst=1 and fail=1, held until reset or relock_req.
REQ-024 relock_req=1 in any state SHALL take priority over every other transition: next state RST, retry_cnt=0, icpsel=ICPSEL_INIT, lpfres=LPFRES_INIT, fail=0, lock=0.
REQ-025 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-026 On reset: state=RST, pll_rst=1, lock=0, fail=0, retry_cnt=0, icpsel=ICPSEL_INIT, lpfres=LPFRES_INIT, counter=0, sync flops=0.
REQ-027 Reset assertion mid-sequence SHALL force these values immediately (asynchronous); the sequence SHALL restart from RST on the first clkin edge after release.

Configuration
REQ-028 SHALL support macro PLL_SEQ_SWEEP_EN.
REQ-029 With PLL_SEQ_SWEEP_EN defined: on each non-final failure, icpsel += 1 (saturating at 63) and lpfres += 1 (mod 8).
REQ-030 Without PLL_SEQ_SWEEP_EN: icpsel and lpfres SHALL be constants ICPSEL_INIT and LPFRES_INIT, and no sweep logic SHALL be synthesized.

Verification (defaults, PLL_SEQ_SWEEP_EN defined unless stated)
REQ-031 Reset release, pll_lock rises and stays high -> pll_rst high for 16 cycles; lock rises 67 cycles after the pll_lock edge (2 sync + 64 stable + 1 register); retry_cnt=0.
REQ-032 pll_lock held 0 -> eight timeouts of 4096 cycles; icpsel steps 8..15 and lpfres steps 2..7,0,1; then fail=1, pll_rst=1, retry_cnt=8, icpsel=15, lpfres=1.
REQ-033 pll_lock drops for 3 cycles at STABLE count 30 -> return to RST; retry_cnt=1, icpsel=9, lpfres=3, 16-cycle pll_rst pulse.
REQ-034 pll_lock falls while in LOCKED -> lock falls 3 cycles later; 16-cycle pll_rst pulse; retry_cnt=0 and icpsel=8 unchanged.
REQ-035 relock_req pulse while in FAIL -> next cycle fail=0, retry_cnt=0, icpsel=8, lpfres=2, pll_rst=1 for 16 cycles.
REQ-036 PLL_SEQ_SWEEP_EN undefined, REQ-032 stimulus -> icpsel=8 and lpfres=2 throughout; fail=1 after eight timeouts.
